im_area_downscale: RTL

Parametrised area-averaging image downscaler for the OV7670→HDMI image-work path. It reads a full input frame from a pixel memory and averages each non-overlapping 2^AW × 2^AH block per colour channel, with optional rounding. Each averaged pixel is written to an output frame memory in raster order. It sits between the camera frame buffer and the downstream image-processing/HDMI buffers, and runs one full frame per start request.

---
 rtl/im_area_downscale.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/im_area_downscale.sv
// rtl/im_area_downscale.sv - area-averaging image downscaler between input and output frame memories
module im_area_downscale #(
  parameter int pIN_IM_WIDTH  = 640,
  parameter int pIN_IM_HEIGHT = 480,
  parameter int pAREA_LOG2_W  = 2,
  parameter int pAREA_LOG2_H  = 2,
  parameter int pCH_NUM       = 3,
  parameter int pCH_W         = 8,
  parameter int pRD_LAT       = 1,
  parameter int pROUND        = 1,
  localparam int PW = pCH_NUM * pCH_W,
  localparam int OW = pIN_IM_WIDTH >> pAREA_LOG2_W,
  localparam int OH = pIN_IM_HEIGHT >> pAREA_LOG2_H,
  localparam int IA = ($clog2(pIN_IM_WIDTH * pIN_IM_HEIGHT) > 0) ? $clog2(pIN_IM_WIDTH * pIN_IM_HEIGHT) : 1,
  localparam int OA = ($clog2(OW * OH) > 0) ? $clog2(OW * OH) : 1
) (
  input  logic          iclk,
  input  logic          irst,
  input  logic          istart,
  input  logic [IA-1:0] idata_start_ptr,
  output logic          omem_rd_en,
  output logic [IA-1:0] oaddr_rd,
  input  logic [PW-1:0] idata_rd,
  output logic          omem_wr_en,
  output logic [OA-1:0] oaddr_wr,
  output logic [PW-1:0] odata_wr,
  output logic          obusy,
  output logic          odone
);

  localparam int S     = pAREA_LOG2_W + pAREA_LOG2_H;
  localparam int AXW   = (pAREA_LOG2_W > 0) ? pAREA_LOG2_W : 1;
  localparam int AYW   = (pAREA_LOG2_H > 0) ? pAREA_LOG2_H : 1;
  localparam int OXW   = (OW > 1) ? $clog2(OW) : 1;
  localparam int OYW   = (OH > 1) ? $clog2(OH) : 1;
  localparam int ACCW  = pCH_W + S;
  localparam int WCW   = $clog2(pRD_LAT + 1);
  localparam int RND_I = (pROUND != 0 && S > 0) ? (1 << ((S > 0) ? S - 1 : 0)) : 0;

  localparam logic [AXW-1:0]  AX_LAST = AXW'((1 << pAREA_LOG2_W) - 1);
  localparam logic [AYW-1:0]  AY_LAST = AYW'((1 << pAREA_LOG2_H) - 1);
  localparam logic [OXW-1:0]  OX_LAST = OXW'(OW - 1);
  localparam logic [OYW-1:0]  OY_LAST = OYW'(OH - 1);
  localparam logic [WCW-1:0]  W_LAST  = WCW'(pRD_LAT - 1);
  localparam logic [ACCW:0]   RND     = (ACCW + 1)'(RND_I);
  localparam logic [ACCW:0]   SAT     = (ACCW + 1)'((1 << pCH_W) - 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  state_t             state, state_nx;
  logic [IA-1:0]      base;
  logic [AXW-1:0]     ax;
  logic [AYW-1:0]     ay;
  logic [OXW-1:0]     ox;
  logic [OYW-1:0]     oy;
  logic [WCW-1:0]     wcnt;
  logic [pRD_LAT-1:0] vld;
  logic [ACCW-1:0]    acc [pCH_NUM];
  logic [OA-1:0]      wr_addr_q;
  logic [PW-1:0]      wr_data_q;
  logic [PW-1:0]      pix;
  logic [ACCW:0]      sum;
  logic               area_last, frame_last;

  assign area_last  = (ax == AX_LAST) && (ay == AY_LAST);
  assign frame_last = (ox == OX_LAST) && (oy == OY_LAST);

  assign omem_rd_en = (state == READ);
  assign oaddr_rd   = IA'(32'(base)
                    + (32'(oy) * 32'(1 << pAREA_LOG2_H) + 32'(ay)) * 32'(pIN_IM_WIDTH)
                    + 32'(ox) * 32'(1 << pAREA_LOG2_W) + 32'(ax));
  assign omem_wr_en = (state == WRITE);
  assign oaddr_wr   = (state == WRITE) ? OA'(32'(oy) * 32'(OW) + 32'(ox)) : wr_addr_q;
  assign odata_wr   = (state == WRITE) ? pix : wr_data_q;
  assign obusy      = (state == READ) || (state == WAIT) || (state == WRITE);
  assign odone      = (state == DONE);

  // state register
  always_ff @(posedge iclk) begin
    if (irst) state <= IDLE;
    else      state <= state_nx;
  end

  // next-state logic: one area of reads, drain the read latency, one write
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (istart) state_nx = READ;
      READ:    if (area_last) state_nx = WAIT;
      WAIT:    if (wcnt == W_LAST) state_nx = WRITE;
      WRITE:   state_nx = frame_last ? DONE : READ;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // per-channel rounding, shift and saturation of the accumulated area sums
  always_comb begin
    pix = '0;
    sum = '0;
    for (int c = 0; c < pCH_NUM; c++) begin
      sum = ({1'b0, acc[c]} + RND) >> S;
      if (sum > SAT) sum = SAT;
      pix[c*pCH_W +: pCH_W] = sum[pCH_W-1:0];
    end
  end

  // base latch, area/output scan counters, read-drain counter and held write outputs
  always_ff @(posedge iclk) begin
    if (irst) begin
      base      <= '0;
      ax        <= '0;
      ay        <= '0;
      ox        <= '0;
      oy        <= '0;
      wcnt      <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      case (state)
        IDLE: if (istart) begin
          base <= idata_start_ptr;
          ax   <= '0;
          ay   <= '0;
          ox   <= '0;
          oy   <= '0;
          wcnt <= '0;
        end
        READ: begin
          wcnt <= '0;
          if (ax == AX_LAST) begin
            ax <= '0;
            if (ay == AY_LAST) ay <= '0;
            else               ay <= ay + 1'b1;
          end else begin
            ax <= ax + 1'b1;
          end
        end
        WAIT: wcnt <= wcnt + 1'b1;
        WRITE: begin
          wr_addr_q <= oaddr_wr;
          wr_data_q <= pix;
          if (ox == OX_LAST) begin
            ox <= '0;
            if (oy == OY_LAST) oy <= '0;
            else               oy <= oy + 1'b1;
          end else begin
            ox <= ox + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // read-valid tag pipe and channel accumulators; cleared on the write and on frame start
  always_ff @(posedge iclk) begin
    if (irst) begin
      vld <= '0;
      for (int c = 0; c < pCH_NUM; c++) acc[c] <= '0;
    end else begin
      vld <= (vld << 1) | pRD_LAT'(state == READ);
      if (state == WRITE || (state == IDLE && istart)) begin
        for (int c = 0; c < pCH_NUM; c++) acc[c] <= '0;
      end else if (vld[pRD_LAT-1]) begin
        for (int c = 0; c < pCH_NUM; c++)
          acc[c] <= acc[c] + ACCW'(idata_rd[c*pCH_W +: pCH_W]);
      end
    end
  end

endmodule
